// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard/stall controller: load-use bubbles, branch flush, memory-wait hold, perf counters
// Control outputs are combinational from state and inputs; state, wait count and counters are registered.
module hazard_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic             id_branch_taken,
   input  logic             id_jump,
   input  logic             ex_memread,
   input  logic [4:0]       ex_rt,
   input  logic             mem_req,
   input  logic             mem_ack,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic             pipe_hold,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERR      = 2'd2
   } state_t;

   localparam logic [16:0] TIMEOUT_L = 17'(MEM_TIMEOUT);

   state_t           state_q, state_d;
   logic [15:0]      wcnt_q, wcnt_d;
   logic             mem_err_q, mem_err_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic load_use;
   logic mem_busy;
   logic hold;
   logic pc_write_c, ifid_write_c, ifid_flush_c, idex_bubble_c, pipe_hold_c;

   always_comb begin
      load_use = ex_memread && (ex_rt != 5'd0) &&
                 ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
      mem_busy = mem_req && !mem_ack;
      // The ack cycle of a memory wait already releases the hold.
      hold     = ((state_q == MEM_WAIT) && !mem_ack) || ((state_q == RUN) && mem_busy);
   end

   always_comb begin
      pc_write_c    = 1'b1;
      ifid_write_c  = 1'b1;
      ifid_flush_c  = 1'b0;
      idex_bubble_c = 1'b0;
      pipe_hold_c   = 1'b0;
      if (!rst_n) begin
         pc_write_c   = 1'b0;
         ifid_write_c = 1'b0;
      end else if (state_q == ERR) begin
         pc_write_c   = 1'b0;
         ifid_write_c = 1'b0;
         pipe_hold_c  = 1'b1;
      end else if (hold) begin
         pc_write_c   = 1'b0;
         ifid_write_c = 1'b0;
         pipe_hold_c  = 1'b1;
      end else if (load_use) begin
         // A branch/jump seen alongside load-use is re-resolved next cycle.
         pc_write_c    = 1'b0;
         ifid_write_c  = 1'b0;
         idex_bubble_c = 1'b1;
      end else if (id_branch_taken || id_jump) begin
         ifid_flush_c = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      case (state_q)
         RUN: begin
            if (mem_busy) begin
               state_d = MEM_WAIT;
               wcnt_d  = 16'd1;
            end
         end
         MEM_WAIT: begin
            // wcnt_q counts busy cycles already spent; this cycle is number wcnt_q+1.
            if (mem_ack) begin
               state_d = RUN;
            end else if (({1'b0, wcnt_q} + 17'd1) >= TIMEOUT_L) begin
               state_d = ERR;
            end else begin
               wcnt_d = wcnt_q + 16'd1;
            end
         end
         ERR: begin
            state_d = ERR;
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   always_comb begin
      mem_err_d   = (state_d == ERR);
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (!pc_write_c && (state_q != ERR) && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (ifid_flush_c && (flush_cnt_q != {CNT_W{1'b1}})) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RUN;
         wcnt_q      <= 16'd0;
         mem_err_q   <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wcnt_q      <= wcnt_d;
         mem_err_q   <= mem_err_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign pc_write    = pc_write_c;
   assign ifid_write  = ifid_write_c;
   assign ifid_flush  = ifid_flush_c;
   assign idex_bubble = idex_bubble_c;
   assign pipe_hold   = pipe_hold_c;
   assign mem_err     = mem_err_q;
   assign stall_cnt   = stall_cnt_q;
   assign flush_cnt   = flush_cnt_q;

endmodule
